// File: rtl/simon_decrypt.sv
// Iterative Simon32/64 block decryptor. It expands the key schedule forward into a
// round-key store, then runs the inverse rounds in reverse key order.
module simon_decrypt #(
  parameter int WORD     = 16,
  parameter int KEYWORDS = 4,
  parameter int ROUNDS   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2*WORD-1:0]          ciphertext,
  input  logic [KEYWORDS*WORD-1:0]   key,
  output logic [2*WORD-1:0]          plaintext,
  output logic                       done,
  output logic                       busy
);

  if (WORD != 16 || KEYWORDS != 4 || ROUNDS != 32) begin : g_unsupported
    $error("simon_decrypt supports only the Simon32/64 parameter set");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEY  = 2'd1;
  localparam logic [1:0] S_DEC  = 2'd2;

  localparam logic [4:0] LastIdx   = 5'(ROUNDS - 1);
  localparam logic [4:0] FirstGen  = 5'(KEYWORDS);

  // z0 constant sequence, MSB is the bit used for k[4].
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] a, input int n);
    return (a << n) | (a >> (WORD - n));
  endfunction

  function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] a, input int n);
    return (a >> n) | (a << (WORD - n));
  endfunction

  logic [1:0]        state_q, state_d;
  logic [WORD-1:0]   x_q, x_d;
  logic [WORD-1:0]   y_q, y_d;
  logic [4:0]        i_q, i_d;
  logic [4:0]        r_q, r_d;
  logic [2*WORD-1:0] pt_q, pt_d;
  logic              done_q, done_d;

  logic [WORD-1:0]   keyStore_q [ROUNDS];

  logic [WORD-1:0]   t1, t2, kNew;
  logic [5:0]        zIdx;
  logic              zBit;
  logic [WORD-1:0]   fOut, yNew;

  // Forward key expansion from the three earlier words already in the store.
  always_comb begin
    zIdx = 6'd61 - (6'(i_q) - 6'd4);
    zBit = Z0[zIdx];
    t1   = ror(keyStore_q[i_q - 5'd1], 3) ^ keyStore_q[i_q - 5'd3];
    t2   = t1 ^ ror(t1, 1);
    kNew = ~keyStore_q[i_q - 5'd4] ^ t2 ^ {{(WORD-1){1'b0}}, zBit} ^ WORD'(3);
  end

  // Inverse round: the old y becomes x, and y is recovered from x, f(y) and the key.
  always_comb begin
    fOut = (rol(y_q, 1) & rol(y_q, 8)) ^ rol(y_q, 2);
    yNew = x_q ^ fOut ^ keyStore_q[r_q];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    i_d     = i_q;
    r_d     = r_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          x_d     = ciphertext[2*WORD-1:WORD];
          y_d     = ciphertext[WORD-1:0];
          i_d     = FirstGen;
          state_d = S_KEY;
        end
      end
      S_KEY: begin
        i_d = i_q + 5'd1;
        if (i_q == LastIdx) begin
          i_d     = 5'd0;
          r_d     = LastIdx;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        x_d = y_q;
        y_d = yNew;
        r_d = r_q - 5'd1;
        if (r_q == 5'd0) begin
          r_d     = 5'd0;
          pt_d    = {y_q, yNew};
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      i_q     <= i_d;
      r_q     <= r_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  // Round-key store has no reset; its contents only matter after a fresh start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_IDLE && en) begin
        for (int k = 0; k < KEYWORDS; k++) begin
          keyStore_q[k] <= key[k*WORD +: WORD];
        end
      end else if (state_q == S_KEY) begin
        keyStore_q[i_q] <= kNew;
      end
    end
  end

  assign plaintext = pt_q;
  assign done      = done_q;
  assign busy      = (state_q == S_KEY) || (state_q == S_DEC);

endmodule

// File: tb/tb_simon_decrypt.sv
// Directed and round-trip checks for simon_decrypt; ciphertexts for non-standard
// vectors come from a small Simon32/64 encryption model.
module tb_simon_decrypt;

  localparam logic [63:0] STD_KEY = 64'h1918111009080100;
  localparam logic [31:0] STD_CT  = 32'hc69be9bb;
  localparam logic [31:0] STD_PT  = 32'h65656877;
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] ciphertext = '0;
  logic [63:0] key = '0;
  logic [31:0] plaintext;
  logic        done;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  simon_decrypt dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .ciphertext(ciphertext),
    .key(key),
    .plaintext(plaintext),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rol16(input logic [15:0] a, input int n);
    return (a << n) | (a >> (16 - n));
  endfunction

  // Forward Simon32/64 encryption, used to produce ciphertexts for the decryptor.
  function automatic logic [31:0] encrypt(input logic [63:0] k, input logic [31:0] p);
    logic [15:0] ks [32];
    logic [15:0] t, x, y, tmp;
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rol16(ks[i-1], 13) ^ ks[i-3];
      t = t ^ rol16(t, 15);
      ks[i] = ~ks[i-4] ^ t ^ {15'b0, Z0[61-(i-4)]} ^ 16'h0003;
    end
    x = p[31:16];
    y = p[15:0];
    for (int r = 0; r < 32; r++) begin
      tmp = x;
      x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ ks[r];
      y = tmp;
    end
    return {x, y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input logic [63:0] k, input logic [31:0] c);
    key = k;
    ciphertext = c;
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  // Steps until done is seen or the budget expires; cycles = -1 on timeout.
  task automatic waitDone(input int limit, output int cycles, output bit busyOk);
    bit seen;
    seen = 1'b0;
    busyOk = 1'b1;
    cycles = 0;
    while (cycles < limit && !seen) begin
      step();
      cycles++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busyOk = 1'b0;
    end
    if (!seen) cycles = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    vectors++;
    if (plaintext !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_plaintext: got %h expected 00000000", plaintext);
    end
  endtask

  task automatic test_standard();
    int cyc;
    bit busyOk;
    startOp(STD_KEY, STD_CT);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL std_busy_after_accept: got %b expected 1", busy);
    end
    waitDone(100, cyc, busyOk);
    vectors++;
    if (cyc !== 60) begin
      miscompares++;
      $display("[TB] FAIL std_latency: got %0d expected 60", cyc);
    end
    vectors++;
    if (plaintext !== STD_PT) begin
      miscompares++;
      $display("[TB] FAIL std_plaintext: got %h expected %h", plaintext, STD_PT);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL std_busy_in_done: got %b expected 0", busy);
    end
    vectors++;
    if (busyOk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL std_busy_window: got %b expected 1", busyOk);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL std_done_pulse_width: got %b expected 0", done);
    end
  endtask

  task automatic test_idle_hold();
    int bad;
    bad = 0;
    en = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (plaintext !== STD_PT || done !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL idle_hold: got %0d bad cycles expected 0 (pt=%h done=%b)",
               bad, plaintext, done);
    end
  endtask

  task automatic test_ignore_busy();
    int pulses, firstAt;
    logic [31:0] ptAt;
    pulses = 0;
    firstAt = -1;
    ptAt = '0;
    startOp(STD_KEY, STD_CT);
    for (int k = 1; k <= 130; k++) begin
      if (k == 10 || k == 40) begin
        en = 1'b1;
        key = 64'hdeadbeef_cafef00d ^ 64'(k);
        ciphertext = 32'h12345678 ^ 32'(k);
      end else begin
        en = 1'b0;
      end
      step();
      if (done === 1'b1) begin
        pulses++;
        if (firstAt < 0) begin
          firstAt = k;
          ptAt = plaintext;
        end
      end
    end
    en = 1'b0;
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL ignore_busy_pulses: got %0d expected 1", pulses);
    end
    vectors++;
    if (firstAt !== 60) begin
      miscompares++;
      $display("[TB] FAIL ignore_busy_latency: got %0d expected 60", firstAt);
    end
    vectors++;
    if (ptAt !== STD_PT) begin
      miscompares++;
      $display("[TB] FAIL ignore_busy_plaintext: got %h expected %h", ptAt, STD_PT);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] keyB;
    logic [31:0] ptB, ctB;
    int pulses;
    int at [2];
    logic [31:0] got [2];
    keyB = 64'h0123456789abcdef;
    ptB = 32'hdeadbeef;
    ctB = encrypt(keyB, ptB);
    pulses = 0;
    at[0] = -1;
    at[1] = -1;
    got[0] = '0;
    got[1] = '0;
    key = STD_KEY;
    ciphertext = STD_CT;
    en = 1'b1;
    step();
    key = keyB;
    ciphertext = ctB;
    for (int k = 1; k <= 140; k++) begin
      step();
      if (k == 61) en = 1'b0;
      if (done === 1'b1) begin
        if (pulses < 2) begin
          at[pulses] = k;
          got[pulses] = plaintext;
        end
        pulses++;
      end
    end
    en = 1'b0;
    vectors++;
    if (pulses !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulses);
    end
    vectors++;
    if (at[0] !== 60) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_latency: got %0d expected 60", at[0]);
    end
    vectors++;
    if (at[1] !== 121) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_at: got %0d expected 121", at[1]);
    end
    vectors++;
    if (got[0] !== STD_PT) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_plaintext: got %h expected %h", got[0], STD_PT);
    end
    vectors++;
    if (got[1] !== ptB) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_plaintext: got %h expected %h", got[1], ptB);
    end
  endtask

  task automatic test_roundtrip();
    logic [63:0] k;
    logic [31:0] p, c;
    int cyc;
    bit busyOk;
    for (int n = 0; n < 200; n++) begin
      k = {$urandom(), $urandom()};
      p = $urandom();
      c = encrypt(k, p);
      startOp(k, c);
      waitDone(100, cyc, busyOk);
      vectors++;
      if (cyc !== 60 || plaintext !== p) begin
        miscompares++;
        $display("[TB] FAIL roundtrip_%0d: got %h after %0d cycles expected %h after 60",
                 n, plaintext, cyc, p);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    startOp(STD_KEY, STD_CT);
    repeat (57) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_done: got %b expected 0", done);
    end
    vectors++;
    if (plaintext !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_plaintext: got %h expected 00000000", plaintext);
    end
    for (int c = 0; c < 80; c++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", pulses);
    end
    test_standard();
  endtask

  initial begin
    test_reset();
    test_standard();
    test_idle_hold();
    test_ignore_busy();
    test_back_to_back();
    test_roundtrip();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
